// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Multi-cycle sequencer for data-memory accesses. Sits between EX/MEM and the
// data bus. A decoded load or store is checked for legality, then issued as one
// valid/ready request. The pipeline is stalled until the response arrives (or
// the timeout fires). The lane-aligned, sign/zero-extended load result is then
// returned together with a one-cycle completion pulse.
//
// Parameters
//   TIMEOUT         Cycles from REQ entry until a forced error completion.
//                   0 disables the timeout.
//
// Ports
//   clk             Clock.
//   rst_n           Asynchronous active-low reset.
//   ex_mem_read     Load request from decode/EX.
//   ex_mem_write    Store request from decode/EX.
//   ex_load_type    000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
//   ex_store_type   00 SB, 01 SH, 10 SW, 11 SD.
//   ex_addr         Effective byte address.
//   ex_wdata        Store data, right-justified.
//   mem_stall       Hold PC and pipeline registers.
//   mem_done        One-cycle completion pulse.
//   mem_err         Error flag, valid with mem_done.
//   load_data       Extended load result, valid with mem_done.
//   bus_req_valid   Request valid.
//   bus_req_ready   Request accepted when valid & ready.
//   bus_req_we      1 = write.
//   bus_req_addr    Doubleword-aligned request address.
//   bus_req_wdata   Store data shifted into its byte lanes.
//   bus_req_wstrb   Byte-lane write mask, 0 for reads.
//   bus_resp_valid  Response / read data valid.
//   bus_resp_rdata  Doubleword-aligned read data.
//   bus_resp_err    Bus error, qualified by bus_resp_valid.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_load_type,
    input  logic [1:0]  ex_store_type,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_wdata,

    output logic        mem_stall,
    output logic        mem_done,
    output logic        mem_err,
    output logic [63:0] load_data,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [63:0] bus_req_addr,
    output logic [63:0] bus_req_wdata,
    output logic [7:0]  bus_req_wstrb,
    input  logic        bus_resp_valid,
    input  logic [63:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    // The counter only has to reach TIMEOUT-1.
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic TO_EN = (TIMEOUT != 0);

    // Access sizes, encoded as log2(bytes).
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic              err_q, err_d;
    logic [63:0]       result_q, result_d;

    // -------------------------------------------------------------------------
    // Decode of the instruction presented in IDLE
    // -------------------------------------------------------------------------
    logic       access;
    logic [1:0] req_size;
    logic       misaligned;
    logic       illegal;
    logic [7:0] strb_base;
    logic       timeout_hit;

    assign access   = ex_mem_read | ex_mem_write;
    assign req_size = ex_mem_read ? ex_load_type[1:0] : ex_store_type;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statements can leave it unassigned and infer a latch.
        misaligned = 1'b0;
        strb_base  = 8'h00;
        unique case (req_size)
            SZ_B: begin misaligned = 1'b0;          strb_base = 8'h01; end
            SZ_H: begin misaligned = ex_addr[0];    strb_base = 8'h03; end
            SZ_W: begin misaligned = |ex_addr[1:0]; strb_base = 8'h0F; end
            SZ_D: begin misaligned = |ex_addr[2:0]; strb_base = 8'hFF; end
            default: ;
        endcase
    end

    // Load type 111 is the only unused encoding; a store cannot be illegal by type.
    assign illegal = (ex_mem_read & ex_mem_write)
                   | (ex_mem_read & (ex_load_type == 3'b111))
                   | misaligned;

    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    // Shift the addressed lane down to bit 0, then extend to 64 bits.
    function automatic logic [63:0] extract(input logic [63:0] rdata,
                                            input logic [2:0]  off,
                                            input logic [1:0]  size,
                                            input logic        sext);
        logic [63:0] r;
        r = rdata >> {off, 3'b000};
        unique case (size)
            SZ_B:    extract = {{56{sext & r[7]}},  r[7:0]};
            SZ_H:    extract = {{48{sext & r[15]}}, r[15:0]};
            SZ_W:    extract = {{32{sext & r[31]}}, r[31:0]};
            default: extract = r;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        size_d   = size_q;
        sext_d   = sext_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        err_d    = err_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    cnt_d    = '0;
                    result_d = '0;
                    if (illegal) begin
                        // Rejected before it reaches the bus.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = ex_addr;
                        we_d    = ex_mem_write;
                        size_d  = req_size;
                        sext_d  = ex_mem_read & ~ex_load_type[2];
                        wdata_d = ex_wdata << {ex_addr[2:0], 3'b000};
                        wstrb_d = ex_mem_write ? (strb_base << ex_addr[2:0]) : 8'h00;
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_req_ready && bus_resp_valid) begin
                    // Response in the acceptance cycle completes directly.
                    err_d    = bus_resp_err;
                    result_d = (bus_resp_err | we_q) ? 64'd0
                             : extract(bus_resp_rdata, addr_q[2:0], size_q, sext_q);
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (bus_req_ready) begin
                    state_d  = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_resp_valid) begin
                    err_d    = bus_resp_err;
                    result_d = (bus_resp_err | we_q) ? 64'd0
                             : extract(bus_resp_rdata, addr_q[2:0], size_q, sext_q);
                    state_d  = S_DONE;
                end else if (timeout_hit) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end
            end

            // The same instruction is still presented here, so inputs are ignored.
            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples values
            // from before the edge regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The request fields come straight from registers, so they stay stable
    // while valid is waiting for ready.
    assign bus_req_valid = (state_q == S_REQ);
    assign bus_req_we    = we_q;
    assign bus_req_addr  = {addr_q[63:3], 3'b000};
    assign bus_req_wdata = wdata_q;
    assign bus_req_wstrb = wstrb_q;

    assign mem_stall = ((state_q == S_IDLE) & access)
                     | (state_q == S_REQ)
                     | (state_q == S_WAIT);
    assign mem_done  = (state_q == S_DONE);
    assign mem_err   = (state_q == S_DONE) & err_q;
    assign load_data = (state_q == S_DONE) ? result_q : 64'd0;

endmodule
